dual_port_mem_param: RTL and testbench

Parametrised two-address memory with independent read and write addresses, per-byte write enables, configurable read latency (1 or 2 cycles), and selectable read-during-write forwarding. After every reset, an internal clear sequencer zeroes the whole array before accepting traffic. It is the next-generation storage block of the memory subsystem and is driven directly by the bench or by upstream control logic.

---
 rtl/dual_port_mem_param.sv | 138 +++++++++++++
 tb/tb_dual_port_mem_param.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/dual_port_mem_param.sv
// dual_port_mem_param
//   Word-addressed storage with independent read and write ports, per-byte
//   write enables, a 1- or 2-cycle registered read path, and optional
//   same-address read-during-write forwarding. After every reset a clear
//   sequencer writes zero to every word; requests are ignored until it ends.
//
// Ports
//   clk        rising-edge clock
//   reset_L    synchronous active-low reset
//   read       read request (addressR)
//   write      write request (addressW, data_in, wr_be)
//   wr_be      byte enables, bit i covers data_in[8i+7:8i]
//   addressR   read address
//   addressW   write address
//   data_in    write data
//   data_out   registered read data, holds while valid_out = 0
//   valid_out  data_out carries a read result this cycle
//   init_done  clear sequence finished, requests accepted
//
// state | meaning
// CLEAR | zeroing mem[cnt] each edge, requests ignored
// READY | normal read/write traffic
module dual_port_mem_param #(
  parameter int ADDR_WIDTH = 4,
  parameter int BUS_SIZE   = 32,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    read,
  input  logic                    write,
  input  logic [BUS_SIZE/8-1:0]   wr_be,
  input  logic [ADDR_WIDTH-1:0]   addressR,
  input  logic [ADDR_WIDTH-1:0]   addressW,
  input  logic [BUS_SIZE-1:0]     data_in,
  output logic [BUS_SIZE-1:0]     data_out,
  output logic                    valid_out,
  output logic                    init_done
);

  localparam int MEM_LENGTH = 1 << ADDR_WIDTH;
  localparam int NBYTES     = BUS_SIZE / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_LENGTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [BUS_SIZE-1:0]     mem [MEM_LENGTH];

  logic                    rd_acc;
  logic                    wr_acc;
  logic                    fwd_hit;
  logic [BUS_SIZE-1:0]     wr_merged;
  logic [BUS_SIZE-1:0]     rd_word;
  logic [BUS_SIZE-1:0]     d1;
  logic                    v1;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state     <= CLEAR;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + ADDR_WIDTH'(1);
          if (cnt == LAST_ADDR) begin
            state     <= READY;
            init_done <= 1'b1;
          end
        end
        READY: state <= READY;
        default: state <= CLEAR;
      endcase
    end
  end

  assign rd_acc = (state == READY) && read;
  assign wr_acc = (state == READY) && write;

  // Word as it will look after this edge's write; also the forwarded value.
  always_comb begin
    wr_merged = mem[addressW];
    for (int i = 0; i < NBYTES; i++) begin
      if (wr_be[i]) wr_merged[8*i +: 8] = data_in[8*i +: 8];
    end
  end

  assign fwd_hit = (BYPASS != 0) && wr_acc && (addressW == addressR);
  assign rd_word = fwd_hit ? wr_merged : mem[addressR];

  // Array has no reset of its own; the clear sequence zeroes it after reset.
  always_ff @(posedge clk) begin
    if (reset_L) begin
      if (state == CLEAR) begin
        mem[cnt] <= '0;
      end else if (wr_acc) begin
        mem[addressW] <= wr_merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) d1 <= rd_word;
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [BUS_SIZE-1:0] d2;
      logic                v2;

      always_ff @(posedge clk) begin
        if (!reset_L) begin
          d2 <= '0;
          v2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) d2 <= d1;
        end
      end

      assign data_out  = d2;
      assign valid_out = v2;
    end else begin : g_lat1
      assign data_out  = d1;
      assign valid_out = v1;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_mem_param.sv
module tb_dual_port_mem_param;

  localparam int AW      = 4;
  localparam int DW      = 32;
  localparam int BE      = DW / 8;
  localparam int MEM_LEN = 1 << AW;
  localparam int RD_LAT  = 1;
  localparam int BYP     = 1;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          read;
  logic          write;
  logic [BE-1:0] wr_be;
  logic [AW-1:0] addressR;
  logic [AW-1:0] addressW;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          init_done;

  dual_port_mem_param #(
    .ADDR_WIDTH(AW), .BUS_SIZE(DW), .RD_LATENCY(RD_LAT), .BYPASS(BYP)
  ) dut (
    .clk(clk), .reset_L(reset_L), .read(read), .write(write), .wr_be(wr_be),
    .addressR(addressR), .addressW(addressW), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: array contents, clear progress, and a queue of read
  // results tagged with the edge after which they must appear.
  typedef struct {
    int          due;
    logic [DW-1:0] d;
  } pend_t;

  logic [DW-1:0] mmem [MEM_LEN];
  pend_t         pq[$];
  bit            m_ready = 0;
  int            clr = 0;
  int            cyc = 0;
  logic [DW-1:0] m_data = '0;
  logic          m_valid = 1'b0;
  logic          m_init = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                          input logic [BE-1:0] be);
    logic [DW-1:0] w;
    w = old;
    for (int i = 0; i < BE; i++) if (be[i]) w[8*i +: 8] = din[8*i +: 8];
    return w;
  endfunction

  task automatic cycle(input logic rst, input logic rd, input logic wr, input logic [BE-1:0] be,
                       input logic [AW-1:0] ar, input logic [AW-1:0] aw, input logic [DW-1:0] din);
    logic [DW-1:0] old_r, nw;
    pend_t p;
    reset_L = rst; read = rd; write = wr; wr_be = be;
    addressR = ar; addressW = aw; data_in = din;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      m_ready = 0; clr = 0; pq.delete();
      m_data = '0; m_valid = 1'b0; m_init = 1'b0;
    end else begin
      if (!m_ready) begin
        mmem[clr] = '0;
        clr++;
        if (clr == MEM_LEN) begin m_ready = 1; m_init = 1'b1; end
      end else begin
        old_r = mmem[ar];
        nw    = merge(mmem[aw], din, be);
        if (rd) begin
          p.due = cyc + RD_LAT - 1;
          p.d   = (BYP != 0 && wr && aw == ar) ? nw : old_r;
          pq.push_back(p);
        end
        if (wr) mmem[aw] = nw;
      end
      m_valid = 1'b0;
      if (pq.size() > 0 && pq[0].due == cyc) begin
        m_valid = 1'b1;
        m_data  = pq[0].d;
        void'(pq.pop_front());
      end
    end
    chk("data_out", data_out, m_data);
    chk("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
    chk("init_done", {31'b0, init_done}, {31'b0, m_init});
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic rand_req(input logic rst);
    cycle(rst, 1'($urandom), 1'($urandom), BE'($urandom), AW'($urandom), AW'($urandom), $urandom);
  endtask

  typedef struct {
    logic          wr;
    logic [BE-1:0] be;
    logic [AW-1:0] aw;
    logic [DW-1:0] din;
    logic          rd;
    logic [AW-1:0] ar;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt[9];

  initial begin
    int n;
    for (int i = 0; i < MEM_LEN; i++) mmem[i] = '0;

    vt[0] = '{1'b1, 4'hF, 4'd3,  32'hAABBCCDD, 1'b0, 4'd0,  32'h0};
    vt[1] = '{1'b1, 4'h5, 4'd3,  32'h11223344, 1'b0, 4'd0,  32'h0};
    vt[2] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd3,  32'hAA22CC44};
    vt[3] = '{1'b1, 4'hF, 4'd5,  32'hDEADBEEF, 1'b1, 4'd5,  (BYP != 0) ? 32'hDEADBEEF : 32'h0};
    vt[4] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd5,  32'hDEADBEEF};
    vt[5] = '{1'b1, 4'hF, 4'd15, 32'h12345678, 1'b1, 4'd3,  32'hAA22CC44};
    vt[6] = '{1'b1, 4'h0, 4'd15, 32'hFFFFFFFF, 1'b1, 4'd15, 32'h12345678};
    vt[7] = '{1'b0, 4'h0, 4'd0,  32'h0,        1'b1, 4'd15, 32'h12345678};
    vt[8] = '{1'b1, 4'h8, 4'd0,  32'hCAFEF00D, 1'b1, 4'd0,  (BYP != 0) ? 32'hCA000000 : 32'h0};

    // Reset, then release with random requests that must be ignored during clear.
    rand_req(1'b0);
    rand_req(1'b0);
    n = 0;
    while (!init_done && n < 40) begin
      rand_req(1'b1);
      n++;
    end
    chk("init_edges", 32'(n), 32'(MEM_LEN));

    for (int a = 0; a < MEM_LEN; a++) cycle(1'b1, 1'b1, 1'b0, '0, AW'(a), '0, '0);
    for (int j = 0; j < RD_LAT; j++) idle();

    foreach (vt[i]) begin
      cycle(1'b1, vt[i].rd, vt[i].wr, vt[i].be, vt[i].ar, vt[i].aw, vt[i].din);
      for (int j = 0; j < RD_LAT - 1; j++) idle();
      if (vt[i].rd) begin
        chk($sformatf("vec%0d_valid", i), {31'b0, valid_out}, 32'd1);
        chk($sformatf("vec%0d_data", i), data_out, vt[i].exp);
      end
    end
    for (int j = 0; j < RD_LAT; j++) idle();

    for (int a = 0; a < MEM_LEN; a++) cycle(1'b1, 1'b0, 1'b1, '1, '0, AW'(a), $urandom);
    for (int a = 0; a < MEM_LEN; a++) cycle(1'b1, 1'b1, 1'b0, '0, AW'(a), '0, '0);
    for (int j = 0; j < RD_LAT; j++) idle();

    for (int k = 0; k < 500; k++) rand_req(1'b1);
    for (int j = 0; j < RD_LAT; j++) idle();

    // Reset while a read of address 3 is in flight.
    cycle(1'b1, 1'b0, 1'b1, '1, '0, 4'd3, 32'h5A5A5A5A);
    cycle(1'b1, 1'b1, 1'b0, '0, 4'd3, '0, '0);
    cycle(1'b0, 1'b1, 1'b0, '0, 4'd3, '0, '0);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_init", {31'b0, init_done}, 32'd0);
    chk("rst_data", data_out, 32'h0);
    for (int k = 0; k < MEM_LEN; k++) rand_req(1'b1);
    chk("reclear_init", {31'b0, init_done}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0, '0, 4'd3, '0, '0);
    for (int j = 0; j < RD_LAT - 1; j++) idle();
    chk("reclear_valid", {31'b0, valid_out}, 32'd1);
    chk("reclear_data3", data_out, 32'h0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
